// File: rtl/mfp_sevenseg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with staged, frame-synchronous display updates.
// Each digit slot is a blanking phase followed by a drive phase; all outputs are registered.
module mfp_sevenseg_scan_ctrl #(
   parameter int SLOT_CYCLES  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        upd,
   input  logic [31:0] hex,
   input  logic [7:0]  en,
   input  logic [7:0]  dp,
   output logic [7:0]  DISPENOUT,
   output logic [7:0]  DISPOUT,
   output logic        pending,
   output logic        frame_done
);

   localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [2:0]       LAST_DIGIT = 3'd7;

   typedef enum logic {
      ST_BLANK,
      ST_DRIVE
   } scan_state_t;

   typedef struct packed {
      logic [31:0] hex;
      logic [7:0]  en;
      logic [7:0]  dp;
   } disp_set_t;

   scan_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic             run_q;
   logic             boundary;
   logic             frame_done_d;

   disp_set_t        in_set;
   disp_set_t        staging_q;
   disp_set_t        active_q;

   logic [3:0]       digit_hex;
   logic [7:0]       dispen_d;
   logic [7:0]       disp_d;

   // Active-low CA..CG pattern for one hex digit.
   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      s = 7'b1111111;
      case (v)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         4'hF: s = 7'b0111000;
      endcase
      return s;
   endfunction

   assign in_set   = '{hex: hex, en: en, dp: dp};
   assign boundary = run_q && (state_q == ST_DRIVE) && (cnt_q == SLOT_LAST) && (idx_q == LAST_DIGIT);

   // Slot sequencing: BLANK for counts 0..BLANK_LAST, DRIVE up to SLOT_LAST, then next digit.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      if (run_q) begin
         unique case (state_q)
            ST_BLANK: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == BLANK_LAST) state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
               if (cnt_q == SLOT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_BLANK;
                  idx_d   = idx_q + 3'd1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         endcase
      end
      // Registered look-ahead so frame_done is high during the boundary cycle itself.
      frame_done_d = (state_d == ST_DRIVE) && (cnt_d == SLOT_LAST) && (idx_d == LAST_DIGIT);
   end

   always_comb begin
      digit_hex = active_q.hex[{idx_q, 2'b00} +: 4];
      dispen_d  = 8'hFF;
      disp_d    = 8'hFF;
      if ((state_q == ST_DRIVE) && active_q.en[idx_q]) begin
         dispen_d[idx_q] = 1'b0;
         disp_d          = {~active_q.dp[idx_q], seg_decode(digit_hex)};
      end
   end

   // run_q holds the scan at slot start until the first clock edge after reset release.
   always_ff @(posedge HCLK or posedge HRESET) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (HRESET) begin
         run_q      <= 1'b0;
         state_q    <= ST_BLANK;
         cnt_q      <= '0;
         idx_q      <= '0;
         frame_done <= 1'b0;
      end else begin
         run_q      <= 1'b1;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         frame_done <= frame_done_d;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         staging_q <= '0;
         active_q  <= '0;
         pending   <= 1'b0;
      end else begin
         if (upd) staging_q <= in_set;
         if (boundary) begin
            active_q <= upd ? in_set : staging_q;
            pending  <= 1'b0;
         end else if (upd) begin
            pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         DISPENOUT <= 8'hFF;
         DISPOUT   <= 8'hFF;
      end else begin
         DISPENOUT <= dispen_d;
         DISPOUT   <= disp_d;
      end
   end

endmodule

// File: tb/tb_mfp_sevenseg_scan_ctrl.sv
// Directed bench for mfp_sevenseg_scan_ctrl with a per-digit scoreboard of expected slot outputs.
module tb_mfp_sevenseg_scan_ctrl;

   localparam int SLOT   = 8;
   localparam int BLANK  = 2;
   localparam int FRAME  = SLOT * 8;

   localparam logic [6:0] SEG_TAB [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   typedef struct packed {
      logic [7:0] an;
      logic [7:0] seg;
   } exp_t;

   logic        HCLK;
   logic        HRESET;
   logic        upd;
   logic [31:0] hex;
   logic [7:0]  en;
   logic [7:0]  dp;
   logic [7:0]  DISPENOUT;
   logic [7:0]  DISPOUT;
   logic        pending;
   logic        frame_done;

   exp_t        sb_q[$];
   exp_t        cur;
   logic [31:0] m_hex;
   logic [7:0]  m_en;
   logic [7:0]  m_dp;
   logic        pend_m;
   int          n_tests;
   int          n_fail;

   mfp_sevenseg_scan_ctrl #(
      .SLOT_CYCLES (SLOT),
      .BLANK_CYCLES(BLANK)
   ) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .upd       (upd),
      .hex       (hex),
      .en        (en),
      .dp        (dp),
      .DISPENOUT (DISPENOUT),
      .DISPOUT   (DISPOUT),
      .pending   (pending),
      .frame_done(frame_done)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach summary");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge HCLK);
   endtask

   function automatic exp_t digit_exp(input int k, input logic [31:0] h, input logic [7:0] e,
                                      input logic [7:0] d);
      exp_t       r;
      logic [3:0] nib;
      r.an  = 8'hFF;
      r.seg = 8'hFF;
      nib   = h[4*k +: 4];
      if (e[k]) begin
         r.an[k] = 1'b0;
         r.seg   = {~d[k], SEG_TAB[nib]};
      end
      return r;
   endfunction

   task automatic push_frame();
      for (int k = 0; k < 8; k++) sb_q.push_back(digit_exp(k, m_hex, m_en, m_dp));
   endtask

   task automatic strobe(input logic [31:0] h, input logic [7:0] e, input logic [7:0] d);
      upd   = 1'b1;
      hex   = h;
      en    = e;
      dp    = d;
      m_hex = h;
      m_en  = e;
      m_dp  = d;
   endtask

   // Tick 1 is the first cycle after a frame boundary; tick FRAME is the next boundary.
   task automatic run_frame(input int fr, input int stop,
                            input int u1, input logic [31:0] h1, input logic [7:0] e1, input logic [7:0] d1,
                            input int u2, input logic [31:0] h2, input logic [7:0] e2, input logic [7:0] d2);
      for (int t = 1; t <= stop; t++) begin
         tick();
         if (t >= 2 && ((t - 2) % SLOT) < BLANK) begin
            check($sformatf("F%0d t%0d blank DISPENOUT", fr, t), DISPENOUT, 8'hFF);
            check($sformatf("F%0d t%0d blank DISPOUT", fr, t), DISPOUT, 8'hFF);
         end else begin
            if (t >= 2 && ((t - 2) % SLOT) == BLANK) begin
               n_tests++;
               assert (sb_q.size() > 0) else begin
                  n_fail++;
                  $error("FAIL F%0d t%0d scoreboard: observed empty queue, expected an entry", fr, t);
               end
               if (sb_q.size() > 0) cur = sb_q.pop_front();
            end
            check($sformatf("F%0d t%0d drive DISPENOUT", fr, t), DISPENOUT, cur.an);
            check($sformatf("F%0d t%0d drive DISPOUT", fr, t), DISPOUT, cur.seg);
         end
         check($sformatf("F%0d t%0d frame_done", fr, t), frame_done, (t == FRAME) ? 1 : 0);
         check($sformatf("F%0d t%0d pending", fr, t), pending, pend_m);
         if (t == u1) begin
            strobe(h1, e1, d1);
            if (t != FRAME) pend_m = 1'b1;
         end else if (t == u2) begin
            strobe(h2, e2, d2);
            if (t != FRAME) pend_m = 1'b1;
         end else begin
            upd = 1'b0;
         end
         if (t == FRAME) begin
            pend_m = 1'b0;
            push_frame();
         end
      end
   endtask

   initial begin
      int  n;
      logic seen;
      n_tests = 0;
      n_fail  = 0;
      HRESET  = 1'b1;
      upd     = 1'b0;
      hex     = '0;
      en      = '0;
      dp      = '0;
      m_hex   = '0;
      m_en    = '0;
      m_dp    = '0;
      pend_m  = 1'b0;
      cur     = '{an: 8'hFF, seg: 8'hFF};

      repeat (3) tick();
      check("reset DISPENOUT", DISPENOUT, 8'hFF);
      check("reset DISPOUT", DISPOUT, 8'hFF);
      check("reset pending", pending, 0);
      check("reset frame_done", frame_done, 0);

      // Release and strobe the first value set together; it waits in staging for the boundary.
      HRESET = 1'b0;
      strobe(32'h76543210, 8'hFF, 8'h00);
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         tick();
         n++;
         upd = 1'b0;
         check($sformatf("first frame n%0d pending", n), pending, 1);
         if (frame_done === 1'b1) seen = 1'b1;
      end
      check("first boundary cycle", n, FRAME);
      pend_m = 1'b0;
      push_frame();

      // Digit 2 disabled with its decimal point set.
      run_frame(1, FRAME, 10, 32'h76543810, 8'hFB, 8'h04, 0, '0, '0, '0);
      // Re-enable digit 2: shows 8 with the decimal point lit.
      run_frame(2, FRAME, 20, 32'h76543810, 8'hFF, 8'h04, 0, '0, '0, '0);
      // Two strobes in one frame: only the second set may ever appear.
      run_frame(3, FRAME, 5, 32'h11111111, 8'hFF, 8'h00, 30, 32'hAAAAAAAA, 8'hFF, 8'hFF);
      // Strobe exactly on the boundary cycle.
      run_frame(4, FRAME, FRAME, 32'hFEDCBA98, 8'h7E, 8'hA5, 0, '0, '0, '0);
      // Stop partway through digit 5 drive with a pending update outstanding.
      run_frame(5, 46, 20, 32'h01234567, 8'hFF, 8'h00, 0, '0, '0, '0);

      HRESET = 1'b1;
      #1;
      check("async reset DISPENOUT", DISPENOUT, 8'hFF);
      check("async reset DISPOUT", DISPOUT, 8'hFF);
      check("async reset pending", pending, 0);
      check("async reset frame_done", frame_done, 0);
      repeat (2) tick();
      check("held reset DISPENOUT", DISPENOUT, 8'hFF);
      check("held reset pending", pending, 0);

      HRESET = 1'b0;
      m_hex  = '0;
      m_en   = '0;
      m_dp   = '0;
      pend_m = 1'b0;
      sb_q.delete();
      cur    = '{an: 8'hFF, seg: 8'hFF};
      for (int i = 1; i <= FRAME; i++) begin
         tick();
         check($sformatf("post-reset n%0d DISPENOUT", i), DISPENOUT, 8'hFF);
         check($sformatf("post-reset n%0d DISPOUT", i), DISPOUT, 8'hFF);
         check($sformatf("post-reset n%0d pending", i), pending, 0);
         check($sformatf("post-reset n%0d frame_done", i), frame_done, (i == FRAME) ? 1 : 0);
      end
      push_frame();
      run_frame(6, FRAME, 0, '0, '0, '0, 0, '0, '0, '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mfp_sevenseg_scan_ctrl.md
MFP_SEVENSEG_SCAN_CTRL -- requirements
Module: mfp_sevenseg_scan_ctrl

Interface
REQ-001 SHALL have parameter SLOT_CYCLES, default 100000, clock cycles per digit slot.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000, inter-digit blanking cycles at start of each slot; legal range 1 .. SLOT_CYCLES-1.
REQ-003 SHALL have port HCLK  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port HRESET  input  1  one clock; reset asynchronous, active-high.
REQ-005 SHALL have port upd  input  1  one-cycle strobe capturing hex, en, dp into staging.
REQ-006 SHALL have port hex  input  32  eight 4-bit digit values; digit i = hex[4i+3:4i].
REQ-007 SHALL have port en  input  8  per-digit enable; 0 = digit dark.
REQ-008 SHALL have port dp  input  8  per-digit decimal point; 1 = lit.
REQ-009 SHALL have port DISPENOUT  output  8  anode enables, active-low, bit i = digit i.
REQ-010 SHALL have port DISPOUT  output  8  segments {DP,CA,CB,CC,CD,CE,CF,CG}, active-low.
REQ-011 SHALL have port pending  output  1  staging holds values not yet applied.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 SHALL keep three register sets: staging, active, and scan state (state, slot counter, digit index 0..7).
REQ-014 SHALL implement states BLANK and DRIVE; each slot = BLANK for BLANK_CYCLES, then DRIVE for SLOT_CYCLES-BLANK_CYCLES, total SLOT_CYCLES cycles.
REQ-015 SHALL in BLANK drive DISPENOUT=8'hFF and DISPOUT=8'hFF.
REQ-016 SHALL in DRIVE for digit k drive DISPENOUT = all ones except bit k = ~active_en[k], and DISPOUT = decode(active_hex[k]) with DP bit = ~active_dp[k]; if active_en[k]=0, DISPOUT=8'hFF.
REQ-017 SHALL register DISPENOUT and DISPOUT (no combinational path from inputs); output changes one cycle after state/index change, applied uniformly.
REQ-018 SHALL advance digit index at end of each DRIVE phase, wrapping 7 -> 0; disabled digits keep their slot (constant frame period 8*SLOT_CYCLES).
REQ-019 SHALL decode hex active-low CA..CG: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-020 SHALL on upd=1 capture hex/en/dp into staging and set pending=1 next cycle.
REQ-021 SHALL define the frame boundary as the cycle ending DRIVE of digit 7; on it copy staging to active, clear pending, and assert frame_done for exactly one cycle.
REQ-022 SHALL, if upd=1 in the boundary cycle, load active directly from the inputs (newest values win), write staging likewise, and leave pending=0.
REQ-023 SHALL ignore repeated upd strobes before the boundary except to overwrite staging (last write wins).
REQ-024 SHALL size slot counter as clog2(SLOT_CYCLES) bits; no overflow or skipped cycle at wrap.

Reset
REQ-025 SHALL on HRESET=1 immediately set DISPENOUT=8'hFF, DISPOUT=8'hFF, pending=0, frame_done=0, state=BLANK, counter=0, digit index=0, staging and active hex/en/dp=0.
REQ-026 SHALL, on HRESET asserted mid-slot, abandon the slot; after release scanning restarts at digit 0 BLANK with all registers at reset values.
REQ-027 SHALL begin first BLANK cycle on the first rising HCLK edge after HRESET deasserts.

Verification (SLOT_CYCLES=8, BLANK_CYCLES=2)
REQ-028 SHALL test: reset release, upd with hex=32'h76543210, en=8'hFF, dp=0 -> pending=1 until first boundary (cycle 64), frame_done pulse there, then digit 0 DRIVE shows DISPENOUT=8'hFE, DISPOUT=8'b1_0000001.
REQ-029 SHALL test: steady scan -> per slot 2 cycles of DISPENOUT=8'hFF then 6 cycles with exactly one low bit, index 0..7 then wrap to 0; frame_done period 64 cycles.
REQ-030 SHALL test: en=8'b1111_1011, dp=8'h04, hex digit 2=8 -> slot 2 DRIVE DISPENOUT=8'hFF, DISPOUT=8'hFF; after en=8'hFF, DISPOUT=8'b0_0000000.
REQ-031 SHALL test: two upd strobes in one frame (hex=1..., then hex=A...) -> only second values appear after boundary; first never displayed.
REQ-032 SHALL test: upd exactly on boundary cycle -> new values shown from digit 0 of next frame, pending stays 0, frame_done single pulse.
REQ-033 SHALL test: HRESET asserted during digit 5 DRIVE -> outputs 8'hFF same cycle (asynchronous), pending=0; after release digit 0 scanned first with all digits dark.
